// File: rtl/fsb_pkg.sv
// Shared types, widths and the chip-select decode for the FSB cycle terminator.
package fsb_pkg;

   localparam int WS_W = 3;
   localparam int TO_W = 10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WS,
      S_IOWAIT,
      S_PWWAIT,
      S_ACK,
      S_VPA,
      S_DRAIN
   } fsb_state_t;

   typedef enum logic [2:0] {
      K_NONE,
      K_ROM,
      K_RAM,
      K_PW,
      K_IO,
      K_IACK
   } fsb_kind_t;

   // Fixed priority: IACK > IO > ROM > posted RAM write > plain RAM.
   function automatic fsb_kind_t fsb_decode(input logic iacs,
                                            input logic iocs,
                                            input logic romcs,
                                            input logic pwcs,
                                            input logic ramcs);
      fsb_kind_t kind;
      if (iacs)       kind = K_IACK;
      else if (iocs)  kind = K_IO;
      else if (romcs) kind = K_ROM;
      else if (pwcs)  kind = K_PW;
      else if (ramcs) kind = K_RAM;
      else            kind = K_NONE;
      return kind;
   endfunction

endpackage

// File: rtl/fsb_cycle_term_if.sv
// CPU-side bus signals seen by the FSB cycle terminator, plus the IOB handshake lines.
interface fsb_cycle_term_if;

   logic BACT;
   logic nWE;
   logic RAMCS;
   logic ROMCS;
   logic IOCS;
   logic IOPWCS;
   logic IACS;
   logic IOACK;
   logic IOPWDONE;
   logic nDTACK;
   logic nVPA;
   logic nBERR;
   logic IOREQ;
   logic IOPWREQ;

   modport slave (
      input  BACT, nWE, RAMCS, ROMCS, IOCS, IOPWCS, IACS, IOACK, IOPWDONE,
      output nDTACK, nVPA, nBERR, IOREQ, IOPWREQ
   );

   modport master (
      output BACT, nWE, RAMCS, ROMCS, IOCS, IOPWCS, IACS, IOACK, IOPWDONE,
      input  nDTACK, nVPA, nBERR, IOREQ, IOPWREQ
   );

endinterface

// File: rtl/fsb_wait_cnt.sv
// Loadable saturating down-counter with a zero flag; shared by wait states and IO timeout.
module fsb_wait_cnt
   import fsb_pkg::*;
#(
   parameter int W = WS_W
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fsb_cycle_term.sv
// FSB-side responder terminating every 68HC000 bus cycle (DTACK/VPA, wait states, IOB handoff,
// 1-deep posted-write buffer). Optional IO/no-select bus-error timeout: FSB_BERR_TIMEOUT_EN.
module fsb_cycle_term
   import fsb_pkg::*;
#(
   parameter int RAM_WS = 0,
   parameter int ROM_WS = 2,
   parameter int TO_CYC = 1023
) (
   input logic             CLK,
   input logic             RES,
   fsb_cycle_term_if.slave bus
);

   if (RAM_WS < 0 || RAM_WS > 7 || ROM_WS < 0 || ROM_WS > 7 ||
       TO_CYC < 1 || TO_CYC >= (1 << TO_W)) begin : g_bad_param
      $error("fsb_cycle_term: parameter out of range");
   end

`ifdef FSB_BERR_TIMEOUT_EN
   localparam int CNT_W = TO_W;
   localparam logic [CNT_W-1:0] TO_LD = CNT_W'(TO_CYC);
`else
   localparam int CNT_W = WS_W;
`endif
   localparam logic [CNT_W-1:0] RAM_LD = CNT_W'(RAM_WS);
   localparam logic [CNT_W-1:0] ROM_LD = CNT_W'(ROM_WS);

   fsb_state_t       r_state;
   logic             r_ndtack;
   logic             r_nvpa;
   logic             r_ioreq;
   logic             r_iopwreq;
`ifdef FSB_BERR_TIMEOUT_EN
   logic             r_nberr;
   logic             r_to_run;
`endif

   fsb_kind_t        w_kind;
   logic             w_pw_free;
   logic             w_cnt_load;
   logic [CNT_W-1:0] w_cnt_val;
   logic             w_cnt_dec;
   logic             w_cnt_zero;

   // Posting is only offered for writes; the buffer frees on the same edge IOPWDONE arrives.
   assign w_kind    = fsb_decode(bus.IACS, bus.IOCS, bus.ROMCS, bus.IOPWCS & ~bus.nWE, bus.RAMCS);
   assign w_pw_free = ~r_iopwreq | bus.IOPWDONE;

   always_comb begin
      // NOTE: every signal gets a default first so no latch can be inferred.
      w_cnt_load = 1'b0;
      w_cnt_val  = '0;
      w_cnt_dec  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.BACT) begin
               case (w_kind)
                  K_ROM: begin w_cnt_load = 1'b1; w_cnt_val = ROM_LD; end
                  K_RAM: begin w_cnt_load = 1'b1; w_cnt_val = RAM_LD; end
                  K_PW: begin
                     if (w_pw_free) begin
                        w_cnt_load = 1'b1;
                        w_cnt_val  = RAM_LD;
                     end
                  end
`ifdef FSB_BERR_TIMEOUT_EN
                  K_IO: begin w_cnt_load = 1'b1; w_cnt_val = TO_LD; end
                  K_NONE: begin
                     if (!r_to_run) begin
                        w_cnt_load = 1'b1;
                        w_cnt_val  = TO_LD;
                     end else begin
                        w_cnt_dec = 1'b1;
                     end
                  end
`endif
                  default: ;
               endcase
            end
         end
         S_PWWAIT: begin
            if (bus.BACT && bus.IOPWDONE) begin
               w_cnt_load = 1'b1;
               w_cnt_val  = RAM_LD;
            end
         end
         S_WS: w_cnt_dec = 1'b1;
`ifdef FSB_BERR_TIMEOUT_EN
         S_IOWAIT: w_cnt_dec = 1'b1;
`endif
         default: ;
      endcase
   end

   fsb_wait_cnt #(.W(CNT_W)) u_cnt (
      .i_clk  (CLK),
      .i_rst  (RES),
      .i_load (w_cnt_load),
      .i_val  (w_cnt_val),
      .i_dec  (w_cnt_dec),
      .o_zero (w_cnt_zero)
   );

   always_ff @(posedge CLK) begin
      if (RES) begin
         r_state   <= S_IDLE;
         r_ndtack  <= 1'b1;
         r_nvpa    <= 1'b1;
         r_ioreq   <= 1'b0;
         r_iopwreq <= 1'b0;
`ifdef FSB_BERR_TIMEOUT_EN
         r_nberr   <= 1'b1;
         r_to_run  <= 1'b0;
`endif
      end else begin
         // A completed posting frees the buffer unless a new posting is accepted below.
         if (bus.IOPWDONE) r_iopwreq <= 1'b0;
`ifdef FSB_BERR_TIMEOUT_EN
         if (!bus.BACT) r_nberr <= 1'b1;
         r_to_run <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               r_ndtack <= 1'b1;
               r_nvpa   <= 1'b1;
               if (bus.BACT) begin
                  case (w_kind)
                     K_IACK: r_state <= S_VPA;
                     K_IO: begin
                        r_state <= S_IOWAIT;
                        if (!r_iopwreq) r_ioreq <= 1'b1;
                     end
                     K_ROM, K_RAM: r_state <= S_WS;
                     K_PW: begin
                        if (w_pw_free) begin
                           r_iopwreq <= 1'b1;
                           r_state   <= S_WS;
                        end else begin
                           r_state <= S_PWWAIT;
                        end
                     end
                     default: begin
`ifdef FSB_BERR_TIMEOUT_EN
                        r_to_run <= 1'b1;
                        if (r_to_run && w_cnt_zero) r_nberr <= 1'b0;
`endif
                     end
                  endcase
               end
            end
            S_WS: begin
               if (!bus.BACT) begin
                  r_state <= S_IDLE;
               end else if (w_cnt_zero) begin
                  r_ndtack <= 1'b0;
                  r_state  <= S_ACK;
               end
            end
            S_PWWAIT: begin
               if (!bus.BACT) begin
                  r_state <= S_IDLE;
               end else if (bus.IOPWDONE) begin
                  r_iopwreq <= 1'b1;
                  r_state   <= S_WS;
               end
            end
            S_IOWAIT: begin
               if (r_ioreq && bus.IOACK) begin
                  r_ioreq <= 1'b0;
                  if (bus.BACT) begin
                     r_ndtack <= 1'b0;
                     r_state  <= S_ACK;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else if (!bus.BACT) begin
                  r_state <= r_ioreq ? S_DRAIN : S_IDLE;
`ifdef FSB_BERR_TIMEOUT_EN
               end else if (w_cnt_zero) begin
                  r_nberr <= 1'b0;
                  r_ioreq <= 1'b0;
                  r_state <= S_DRAIN;
`endif
               end else if (!r_iopwreq) begin
                  r_ioreq <= 1'b1;
               end
            end
            S_DRAIN: begin
               // With IOREQ dropped by a timeout there is nothing to drain; wait for AS to end.
               if (r_ioreq) begin
                  if (bus.IOACK) begin
                     r_ioreq <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end else if (!bus.BACT) begin
                  r_state <= S_IDLE;
               end
            end
            S_ACK: begin
               if (!bus.BACT) r_state <= S_IDLE;
            end
            S_VPA: begin
               if (bus.BACT) r_nvpa <= 1'b0;
               else          r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.nDTACK  = r_ndtack;
   assign bus.nVPA    = r_nvpa;
   assign bus.IOREQ   = r_ioreq;
   assign bus.IOPWREQ = r_iopwreq;
`ifdef FSB_BERR_TIMEOUT_EN
   assign bus.nBERR   = r_nberr;
`else
   assign bus.nBERR   = 1'b1;
`endif

endmodule

// File: tb/tb_fsb_cycle_term.sv
// Scoreboard bench: expected output transitions {nDTACK,nVPA,nBERR,IOREQ,IOPWREQ} with edge numbers
// are queued by the stimulus; a negedge monitor pops one entry per observed change.
module tb_fsb_cycle_term;

   typedef struct {
      int         at_edge;
      logic [4:0] vec;
      string      name;
   } exp_t;

   logic clk;
   logic res;
   int   edge_n   = 0;
   int   checks   = 0;
   int   failures = 0;
   bit   mon_en   = 1'b0;
   logic [4:0] prev_vec;
   exp_t exp_q[$];

   fsb_cycle_term_if bus ();

   fsb_cycle_term #(
      .RAM_WS (0),
      .ROM_WS (2),
      .TO_CYC (16)
   ) dut (
      .CLK (clk),
      .RES (res),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   function automatic logic [4:0] out_vec();
      return {bus.nDTACK, bus.nVPA, bus.nBERR, bus.IOREQ, bus.IOPWREQ};
   endfunction

   // Returns just after edge n-1, so anything driven now is sampled at edge n.
   task automatic at(input int n);
      while (edge_n < n - 1) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic bact, input logic iacs, input logic iocs, input logic romcs,
                        input logic pwcs, input logic ramcs, input logic nwe);
      bus.BACT   = bact;
      bus.IACS   = iacs;
      bus.IOCS   = iocs;
      bus.ROMCS  = romcs;
      bus.IOPWCS = pwcs;
      bus.RAMCS  = ramcs;
      bus.nWE    = nwe;
   endtask

   task automatic idle_bus();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic expect_ev(input int e, input logic [4:0] v, input string name);
      exp_t x;
      x.at_edge = e;
      x.vec     = v;
      x.name    = name;
      exp_q.push_back(x);
   endtask

   always @(negedge clk) begin
      logic [4:0] cur;
      exp_t       x;
      if (mon_en) begin
         cur = out_vec();
         if (cur !== prev_vec) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_change: edge=%0d out=%b, required no change from %b",
                        edge_n, cur, prev_vec);
            end else begin
               x = exp_q.pop_front();
               if (x.at_edge != edge_n || x.vec !== cur) begin
                  failures++;
                  $display("FAIL %s: edge=%0d out=%b, required edge=%0d out=%b",
                           x.name, edge_n, cur, x.at_edge, x.vec);
               end
            end
            prev_vec = cur;
         end
      end
   end

   initial begin
      res          = 1'b1;
      bus.IOACK    = 1'b0;
      bus.IOPWDONE = 1'b0;
      idle_bus();

      at(6);  res = 1'b0;
      at(8);
      checks++;
      if (out_vec() !== 5'b11100) begin
         failures++;
         $display("FAIL reset: out=%b, required 11100", out_vec());
      end
      prev_vec = out_vec();
      mon_en   = 1'b1;

      // 1. RAM read, zero wait states.
      expect_ev(11, 5'b01100, "ram_ack");
      expect_ev(15, 5'b11100, "ram_release");
      at(10); drive(1, 0, 0, 0, 0, 1, 1);
      at(14); idle_bus();

      // 2. ROM read, two wait states.
      expect_ev(23, 5'b01100, "rom_ack");
      expect_ev(26, 5'b11100, "rom_release");
      at(20); drive(1, 0, 0, 1, 0, 0, 1);
      at(25); idle_bus();

      // 3. Posted write fills the buffer, then an IO write waits for it to drain.
      expect_ev(30, 5'b11101, "pw_post");
      expect_ev(31, 5'b01101, "pw_ack");
      expect_ev(34, 5'b11101, "pw_release");
      expect_ev(40, 5'b11100, "io_pw_drained");
      expect_ev(41, 5'b11110, "io_req_rise");
      expect_ev(47, 5'b01100, "io_ack_req_fall");
      expect_ev(51, 5'b11100, "io_release");
      at(30); drive(1, 0, 0, 0, 1, 1, 0);
      at(33); idle_bus();
      at(36); drive(1, 0, 1, 0, 0, 0, 0);
      at(40); bus.IOPWDONE = 1'b1;
      at(41); bus.IOPWDONE = 1'b0;
      at(47); bus.IOACK = 1'b1;
      at(48); bus.IOACK = 1'b0;
      at(50); idle_bus();

      // 4. Back-to-back posted writes; second stalls until IOPWDONE.
      expect_ev(60, 5'b11101, "pw1_post");
      expect_ev(61, 5'b01101, "pw1_ack");
      expect_ev(64, 5'b11101, "pw1_release");
      expect_ev(70, 5'b01101, "pw2_ack_after_done");
      expect_ev(73, 5'b11101, "pw2_release");
      at(60); drive(1, 0, 0, 0, 1, 1, 0);
      at(63); idle_bus();
      at(65); drive(1, 0, 0, 0, 1, 1, 0);
      at(69); bus.IOPWDONE = 1'b1;
      at(70); bus.IOPWDONE = 1'b0;
      at(72); idle_bus();

      // IOPWDONE coincident with a new posting: buffer stays full, then drains.
      expect_ev(77, 5'b01101, "pw3_same_edge_ack");
      expect_ev(80, 5'b11101, "pw3_release");
      expect_ev(82, 5'b11100, "pw3_drained");
      at(76); drive(1, 0, 0, 0, 1, 1, 0); bus.IOPWDONE = 1'b1;
      at(77); bus.IOPWDONE = 1'b0;
      at(79); idle_bus();
      at(82); bus.IOPWDONE = 1'b1;
      at(83); bus.IOPWDONE = 1'b0;

      // 5. Interrupt acknowledge: nVPA only.
      expect_ev(87, 5'b10100, "iack_vpa");
      expect_ev(91, 5'b11100, "iack_release");
      at(86); drive(1, 1, 0, 0, 0, 0, 1);
      at(90); idle_bus();

      // ROM cycle aborted in WS gives no strobe; following RAM cycle is normal.
      expect_ev(99, 5'b01100, "post_abort_ack");
      expect_ev(102, 5'b11100, "post_abort_release");
      at(94); drive(1, 0, 0, 1, 0, 0, 1);
      at(95); idle_bus();
      at(98); drive(1, 0, 0, 0, 0, 1, 1);
      at(101); idle_bus();

      // IO cycle aborted with IOREQ up drains until IOACK without a strobe.
      expect_ev(105, 5'b11110, "drain_req");
      expect_ev(111, 5'b11100, "drain_done");
      expect_ev(115, 5'b01100, "post_drain_ack");
      expect_ev(118, 5'b11100, "post_drain_release");
      at(105); drive(1, 0, 1, 0, 0, 0, 0);
      at(108); idle_bus();
      at(111); bus.IOACK = 1'b1;
      at(112); bus.IOACK = 1'b0;
      at(114); drive(1, 0, 0, 0, 0, 1, 1);
      at(117); idle_bus();

      // No-select cycle: never acked; bus error only with the timeout build.
`ifdef FSB_BERR_TIMEOUT_EN
      expect_ev(138, 5'b11000, "nosel_berr");
      expect_ev(140, 5'b11100, "nosel_berr_release");
`endif
      at(121); drive(1, 0, 0, 0, 0, 0, 1);
      at(140); idle_bus();

      // 6. IO cycle whose IOACK comes late.
      expect_ev(145, 5'b11110, "io6_req");
`ifdef FSB_BERR_TIMEOUT_EN
      expect_ev(162, 5'b11000, "io6_timeout_berr");
      expect_ev(165, 5'b11100, "io6_berr_release");
`else
      expect_ev(168, 5'b11100, "io6_late_ack_drain");
`endif
      expect_ev(172, 5'b01100, "io6_next_ack");
      expect_ev(175, 5'b11100, "io6_next_release");
      at(145); drive(1, 0, 1, 0, 0, 0, 0);
      at(165); idle_bus();
      at(168); bus.IOACK = 1'b1;
      at(169); bus.IOACK = 1'b0;
      at(171); drive(1, 0, 0, 0, 0, 1, 1);
      at(174); idle_bus();

      // Reset mid-cycle discards the pending posted write.
      expect_ev(180, 5'b11101, "rst_pw_post");
      expect_ev(181, 5'b01101, "rst_pw_ack");
      expect_ev(183, 5'b11100, "rst_midcycle");
      at(180); drive(1, 0, 0, 0, 1, 1, 0);
      at(183); res = 1'b1;
      at(184); res = 1'b0; idle_bus();

      at(192);
      while (exp_q.size() != 0) begin
         exp_t x;
         x = exp_q.pop_front();
         checks++;
         failures++;
         $display("FAIL %s: no transition seen, required edge=%0d out=%b", x.name, x.at_edge, x.vec);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
